// File: rtl/rtf65002_ibuf_if.sv
// rtf65002_ibuf_if: word fetch bus between the instruction buffer and memory
//    master (ibuf): drives fetch_req_o/fetch_adr_o, samples fetch_ack_i/fetch_dat_i
//    slave (memory): the mirror image
interface rtf65002_ibuf_if #(parameter int AW = 32);
   logic          fetch_req_o;
   logic [AW-1:0] fetch_adr_o;
   logic          fetch_ack_i;
   logic [31:0]   fetch_dat_i;
   modport master(output fetch_req_o, fetch_adr_o, input fetch_ack_i, fetch_dat_i);
   modport slave(input fetch_req_o, fetch_adr_o, output fetch_ack_i, fetch_dat_i);
endinterface

// File: rtl/rtf65002_ibuf.sv
// rtf65002_ibuf: circular byte queue that aligns fetched words into instruction bytes
//    clk_i/rst_i        clock, synchronous active-high reset
//    flush_i/flush_pc_i discard queue and restart fetch at a byte PC
//    bus                word fetch bus (request, word address, ack, little-endian data)
//    ins_o/ins_avail_o  next 8 bytes opcode first, and how many of them are valid
//    adv_i/adv_len_i    consume an instruction of the given length
//    pc_o/adv_err_o     byte PC of ins_o[7:0], sticky illegal-advance flag
module rtf65002_ibuf #(
   parameter int DEPTH = 16,
   parameter int AW    = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic [AW-1:0]         flush_pc_i,
   rtf65002_ibuf_if.master       bus,
   output logic [63:0]           ins_o,
   output logic [3:0]            ins_avail_o,
   input  logic                  adv_i,
   input  logic [3:0]            adv_len_i,
   output logic [AW-1:0]         pc_o,
   output logic                  adv_err_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] head, tail;
   logic [CW-1:0] count, count_nx;
   logic [1:0]    skip;
   logic [2:0]    push;
   logic          run, acc, adv_ok;
   genvar g;
   for (g = 0; g < 8; g++) begin : g_ins
      assign ins_o[8*g +: 8] = mem[head + PW'(g)];
   end
   // run holds fetch off after reset until the first flush supplies a start PC
   always_comb begin
      ins_avail_o = count > CW'(8) ? 4'd8 : 4'(count);
      acc         = bus.fetch_req_o && bus.fetch_ack_i && !flush_i;
      adv_ok      = adv_i && adv_len_i <= ins_avail_o;
      push        = acc ? 3'd4 - {1'b0, skip} : 3'd0;
      count_nx    = count - CW'(adv_ok ? adv_len_i : 4'd0) + CW'(push);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count           <= '0;
         head            <= '0;
         tail            <= '0;
         pc_o            <= '0;
         bus.fetch_adr_o <= '0;
         bus.fetch_req_o <= 1'b0;
         adv_err_o       <= 1'b0;
         skip            <= 2'd0;
         run             <= 1'b0;
      end else if (flush_i) begin
         count           <= '0;
         head            <= '0;
         tail            <= '0;
         pc_o            <= flush_pc_i;
         bus.fetch_adr_o <= {flush_pc_i[AW-1:2], 2'b00};
         bus.fetch_req_o <= 1'b0;
         adv_err_o       <= 1'b0;
         skip            <= flush_pc_i[1:0];
         run             <= 1'b1;
      end else begin
         if (acc) begin
            // bytes below skip precede the flush PC within the first word and are dropped
            for (int j = 0; j < 4; j++)
               if (j >= int'(skip)) mem[tail + PW'(j) - PW'(skip)] <= bus.fetch_dat_i[8*j +: 8];
            tail            <= tail + PW'(push);
            bus.fetch_adr_o <= bus.fetch_adr_o + AW'(4);
            skip            <= 2'd0;
         end
         if (adv_ok) begin
            head <= head + PW'(adv_len_i);
            pc_o <= pc_o + AW'(adv_len_i);
         end
         if (adv_i && !adv_ok) adv_err_o <= 1'b1;
         count           <= count_nx;
         bus.fetch_req_o <= run && count_nx <= CW'(DEPTH - 4);
      end
   end
endmodule

// File: tb/tb_rtf65002_ibuf.sv
// tb_rtf65002_ibuf: directed self-checking bench for rtf65002_ibuf
module tb_rtf65002_ibuf;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic [63:0] ins;
   logic [3:0]  avail;
   logic        adv = 1'b0;
   logic [3:0]  adv_len = '0;
   logic [31:0] pc;
   logic        err;
   int          checks = 0;
   int          errors = 0;
   rtf65002_ibuf_if #(.AW(32)) bus ();
   rtf65002_ibuf #(.DEPTH(16), .AW(32)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_pc_i(flush_pc), .bus(bus),
      .ins_o(ins), .ins_avail_o(avail), .adv_i(adv), .adv_len_i(adv_len),
      .pc_o(pc), .adv_err_o(err)
   );
   always #5 clk = ~clk;
   always @(negedge clk)
      if (!rst && dut.count > 5'd16) begin
         errors++;
         $display("FAIL count_range got %0d exp <=16", dut.count);
      end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_flush(input logic [31:0] p);
      flush = 1'b1;
      flush_pc = p;
      tick();
      flush = 1'b0;
   endtask
   task automatic wait_req();
      for (int k = 0; k < 20 && !bus.fetch_req_o; k++) tick();
      checks++;
      if (bus.fetch_req_o !== 1'b1) begin errors++; $display("FAIL req_timeout got %b exp 1", bus.fetch_req_o); end
   endtask
   task automatic ack_word(input logic [31:0] d);
      wait_req();
      bus.fetch_ack_i = 1'b1;
      bus.fetch_dat_i = d;
      tick();
      bus.fetch_ack_i = 1'b0;
   endtask
   task automatic test_reset();
      tick();
      tick();
      rst = 1'b0;
      checks += 5;
      if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc); end
      if (bus.fetch_adr_o !== 32'h0) begin errors++; $display("FAIL rst_adr got %h exp 0", bus.fetch_adr_o); end
      if (bus.fetch_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.fetch_req_o); end
      if (avail !== 4'd0) begin errors++; $display("FAIL rst_avail got %0d exp 0", avail); end
      if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
      repeat (4) tick();
      checks++;
      if (bus.fetch_req_o !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", bus.fetch_req_o); end
   endtask
   task automatic test_fill();
      do_flush(32'h1000);
      checks++;
      if (bus.fetch_req_o !== 1'b0) begin errors++; $display("FAIL fill_req_n1 got %b exp 0", bus.fetch_req_o); end
      tick();
      checks += 2;
      if (bus.fetch_req_o !== 1'b1) begin errors++; $display("FAIL fill_req_n2 got %b exp 1", bus.fetch_req_o); end
      if (bus.fetch_adr_o !== 32'h1000) begin errors++; $display("FAIL fill_adr_n2 got %h exp 1000", bus.fetch_adr_o); end
      ack_word(32'h03020100);
      checks++;
      if (avail !== 4'd4) begin errors++; $display("FAIL fill_avail1 got %0d exp 4", avail); end
      ack_word(32'h07060504);
      ack_word(32'h0B0A0908);
      checks++;
      if (bus.fetch_req_o !== 1'b1) begin errors++; $display("FAIL fill_req12 got %b exp 1", bus.fetch_req_o); end
      ack_word(32'h0F0E0D0C);
      checks += 5;
      if (ins !== 64'h0706050403020100) begin errors++; $display("FAIL fill_ins got %h exp 0706050403020100", ins); end
      if (avail !== 4'd8) begin errors++; $display("FAIL fill_avail got %0d exp 8", avail); end
      if (pc !== 32'h1000) begin errors++; $display("FAIL fill_pc got %h exp 1000", pc); end
      if (bus.fetch_adr_o !== 32'h1010) begin errors++; $display("FAIL fill_adr got %h exp 1010", bus.fetch_adr_o); end
      if (bus.fetch_req_o !== 1'b0) begin errors++; $display("FAIL fill_req_full got %b exp 0", bus.fetch_req_o); end
      tick();
      checks++;
      if (bus.fetch_req_o !== 1'b0) begin errors++; $display("FAIL fill_req_hold got %b exp 0", bus.fetch_req_o); end
   endtask
   task automatic test_unaligned();
      do_flush(32'h1003);
      tick();
      checks++;
      if (bus.fetch_adr_o !== 32'h1000) begin errors++; $display("FAIL ua_adr0 got %h exp 1000", bus.fetch_adr_o); end
      ack_word(32'hDDCCBBAA);
      checks += 4;
      if (avail !== 4'd1) begin errors++; $display("FAIL ua_avail got %0d exp 1", avail); end
      if (ins[7:0] !== 8'hDD) begin errors++; $display("FAIL ua_byte got %h exp DD", ins[7:0]); end
      if (pc !== 32'h1003) begin errors++; $display("FAIL ua_pc got %h exp 1003", pc); end
      if (bus.fetch_adr_o !== 32'h1004) begin errors++; $display("FAIL ua_adr got %h exp 1004", bus.fetch_adr_o); end
   endtask
   task automatic test_adv_ack();
      do_flush(32'h2000);
      ack_word(32'h13121110);
      ack_word(32'h17161514);
      wait_req();
      bus.fetch_ack_i = 1'b1;
      bus.fetch_dat_i = 32'h1B1A1918;
      adv = 1'b1;
      adv_len = 4'd3;
      tick();
      bus.fetch_ack_i = 1'b0;
      adv = 1'b0;
      checks += 5;
      if (dut.count !== 5'd9) begin errors++; $display("FAIL aa_count got %0d exp 9", dut.count); end
      if (avail !== 4'd8) begin errors++; $display("FAIL aa_avail got %0d exp 8", avail); end
      if (pc !== 32'h2003) begin errors++; $display("FAIL aa_pc got %h exp 2003", pc); end
      if (ins !== 64'h1A19181716151413) begin errors++; $display("FAIL aa_ins got %h exp 1A19181716151413", ins); end
      if (err !== 1'b0) begin errors++; $display("FAIL aa_err got %b exp 0", err); end
   endtask
   task automatic test_adv_err();
      do_flush(32'h3000);
      ack_word(32'h23222120);
      adv = 1'b1;
      adv_len = 4'd0;
      tick();
      checks += 2;
      if (pc !== 32'h3000) begin errors++; $display("FAIL ae_zero_pc got %h exp 3000", pc); end
      if (err !== 1'b0) begin errors++; $display("FAIL ae_zero_err got %b exp 0", err); end
      adv_len = 4'd2;
      tick();
      checks += 2;
      if (pc !== 32'h3002) begin errors++; $display("FAIL ae_two_pc got %h exp 3002", pc); end
      if (avail !== 4'd2) begin errors++; $display("FAIL ae_two_avail got %0d exp 2", avail); end
      adv_len = 4'd5;
      tick();
      adv = 1'b0;
      checks += 4;
      if (err !== 1'b1) begin errors++; $display("FAIL ae_err got %b exp 1", err); end
      if (pc !== 32'h3002) begin errors++; $display("FAIL ae_pc got %h exp 3002", pc); end
      if (avail !== 4'd2) begin errors++; $display("FAIL ae_avail got %0d exp 2", avail); end
      if (ins[15:0] !== 16'h2322) begin errors++; $display("FAIL ae_ins got %h exp 2322", ins[15:0]); end
      repeat (3) tick();
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL ae_sticky got %b exp 1", err); end
      do_flush(32'h3100);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL ae_clear got %b exp 0", err); end
   endtask
   task automatic test_flush_ack();
      do_flush(32'h4000);
      ack_word(32'h43424140);
      wait_req();
      flush = 1'b1;
      flush_pc = 32'h4567;
      bus.fetch_ack_i = 1'b1;
      bus.fetch_dat_i = 32'h47464544;
      tick();
      flush = 1'b0;
      bus.fetch_ack_i = 1'b0;
      checks += 3;
      if (avail !== 4'd0) begin errors++; $display("FAIL fa_avail got %0d exp 0", avail); end
      if (bus.fetch_req_o !== 1'b0) begin errors++; $display("FAIL fa_req_n1 got %b exp 0", bus.fetch_req_o); end
      if (pc !== 32'h4567) begin errors++; $display("FAIL fa_pc got %h exp 4567", pc); end
      tick();
      checks += 3;
      if (bus.fetch_req_o !== 1'b1) begin errors++; $display("FAIL fa_req_n2 got %b exp 1", bus.fetch_req_o); end
      if (bus.fetch_adr_o !== 32'h4564) begin errors++; $display("FAIL fa_adr got %h exp 4564", bus.fetch_adr_o); end
      if (avail !== 4'd0) begin errors++; $display("FAIL fa_avail2 got %0d exp 0", avail); end
      do_flush(32'h5000);
      do_flush(32'h6001);
      checks++;
      if (bus.fetch_req_o !== 1'b0) begin errors++; $display("FAIL b2b_req_n1 got %b exp 0", bus.fetch_req_o); end
      tick();
      checks += 3;
      if (bus.fetch_req_o !== 1'b1) begin errors++; $display("FAIL b2b_req_n2 got %b exp 1", bus.fetch_req_o); end
      if (bus.fetch_adr_o !== 32'h6000) begin errors++; $display("FAIL b2b_adr got %h exp 6000", bus.fetch_adr_o); end
      if (pc !== 32'h6001) begin errors++; $display("FAIL b2b_pc got %h exp 6001", pc); end
   endtask
   task automatic test_wrap();
      do_flush(32'hFFFFFFFC);
      tick();
      checks++;
      if (bus.fetch_adr_o !== 32'hFFFFFFFC) begin errors++; $display("FAIL wr_adr0 got %h exp FFFFFFFC", bus.fetch_adr_o); end
      ack_word(32'h33323130);
      checks++;
      if (bus.fetch_adr_o !== 32'h0) begin errors++; $display("FAIL wr_adr1 got %h exp 0", bus.fetch_adr_o); end
      ack_word(32'h37363534);
      checks += 2;
      if (bus.fetch_adr_o !== 32'h4) begin errors++; $display("FAIL wr_adr2 got %h exp 4", bus.fetch_adr_o); end
      if (ins !== 64'h3736353433323130) begin errors++; $display("FAIL wr_ins got %h exp 3736353433323130", ins); end
      adv = 1'b1;
      adv_len = 4'd8;
      tick();
      adv = 1'b0;
      checks += 2;
      if (pc !== 32'h4) begin errors++; $display("FAIL wr_pc got %h exp 4", pc); end
      if (avail !== 4'd0) begin errors++; $display("FAIL wr_avail got %0d exp 0", avail); end
   endtask
   task automatic test_reset_mid();
      adv = 1'b1;
      adv_len = 4'd1;
      tick();
      adv = 1'b0;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL rm_err_set got %b exp 1", err); end
      wait_req();
      rst = 1'b1;
      bus.fetch_ack_i = 1'b1;
      bus.fetch_dat_i = 32'h55555555;
      adv = 1'b1;
      tick();
      rst = 1'b0;
      bus.fetch_ack_i = 1'b0;
      adv = 1'b0;
      checks += 5;
      if (pc !== 32'h0) begin errors++; $display("FAIL rm_pc got %h exp 0", pc); end
      if (bus.fetch_adr_o !== 32'h0) begin errors++; $display("FAIL rm_adr got %h exp 0", bus.fetch_adr_o); end
      if (bus.fetch_req_o !== 1'b0) begin errors++; $display("FAIL rm_req got %b exp 0", bus.fetch_req_o); end
      if (avail !== 4'd0) begin errors++; $display("FAIL rm_avail got %0d exp 0", avail); end
      if (err !== 1'b0) begin errors++; $display("FAIL rm_err got %b exp 0", err); end
   endtask
   initial begin
      bus.fetch_ack_i = 1'b0;
      bus.fetch_dat_i = '0;
      test_reset();
      test_fill();
      test_unaligned();
      test_adv_ack();
      test_adv_err();
      test_flush_ack();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rtf65002_ibuf.md
Name: rtf65002_ibuf

Overview:
Instruction byte buffer/aligner for the rtf65002 fetch path. It fetches 32-bit words from memory into a 16-byte circular byte queue and presents the next 8 instruction bytes, opcode first, to the decoder. It then advances by the instruction length the decoder's length table reports. It is the consuming side of the per-opcode PC-increment information, and it owns the byte-accurate PC.

Parameters:
DEPTH, 16, queue capacity in bytes; fixed power of two, must be at least 12.
AW, 32, address width in bits.

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_i  in  1  synchronous active-high reset
flush_i  in  1  discard queue contents, restart fetch at flush_pc_i
flush_pc_i  in  AW  new byte PC (any alignment)
fetch_req_o  out  1  word fetch request, registered
fetch_adr_o  out  AW  word address of the request; [1:0] always 0
fetch_ack_i  in  1  fetch_dat_i valid for current request
fetch_dat_i  in  32  fetched word, little-endian (byte 0 = [7:0])
ins_o  out  64  head bytes; [7:0] = byte at pc_o (opcode), [15:8] = pc_o+1, and so on
ins_avail_o  out  4  valid head bytes, min(count,8)
adv_i  in  1  consume adv_len_i bytes this cycle
adv_len_i  in  4  instruction length, 0..8
pc_o  out  AW  byte address of ins_o[7:0]
adv_err_o  out  1  sticky: illegal advance attempted

Behaviour:
- Reset (rst_i=1 at an edge):
  - count=0, head=tail=0, pc_o=0, fetch_adr_o=0, fetch_req_o=0, adv_err_o=0, skip=0.
  - The block stays idle until the first flush_i; the reset vector is loaded via flush.
  - Reset overrides flush, ack and advance in the same cycle.
- Fetch request:
  - fetch_req_o is next-set to 1 when not flushing and (count - accepted-advance + pushed) <= DEPTH-4.
  - It stays asserted until an ack; at most one request is outstanding.
  - After an ack it may re-assert the following cycle if room remains.
- Ack accept:
  - fetch_ack_i counts only when fetch_req_o=1 and flush_i=0; otherwise it is ignored.
  - On accept, bytes skip..3 of fetch_dat_i are written at the tail in ascending order.
  - tail += 4-skip, count += 4-skip, fetch_adr_o += 4 (modulo 2^AW), skip then clears to 0.
  - Bytes are visible in ins_o/ins_avail_o the cycle after the ack (1-cycle latency).
- Advance:
  - Legal when adv_len_i <= ins_avail_o. Then head += adv_len_i, count -= adv_len_i, pc_o += adv_len_i (wraps modulo 2^AW).
  - adv_len_i=0 is a legal no-op.
  - An illegal advance (adv_len_i > ins_avail_o, or > 8) changes no state and sets adv_err_o=1. adv_err_o clears only on flush_i or reset.
- Simultaneous advance and ack: both apply; count_next = count - adv_len_i + (4-skip). Room is guaranteed because the request was issued only when count <= DEPTH-4.
- Flush at cycle n:
  - Flush has priority over ack and advance in cycle n.
  - Next state: count=0, head=tail=0, pc_o=flush_pc_i, fetch_adr_o={flush_pc_i[AW-1:2],2'b00}, skip=flush_pc_i[1:0], adv_err_o=0.
  - fetch_req_o=0 at n+1, so any in-flight bus cycle aborts; the bus must drop it when req falls.
  - fetch_req_o=1 at n+2 with the new address.
  - Back-to-back flushes each restart this sequence; the last one wins.
- Outputs:
  - ins_o bytes at index >= ins_avail_o are don't-care.
  - ins_avail_o saturates at 8 while count ranges 0..DEPTH.
  - count never exceeds DEPTH and never goes negative; a violation is a design error, caught by an assertion in the bench.
- Implementation: byte-wide circular storage, 4-bit head/tail pointers (wrap modulo DEPTH), 5-bit count.

Test Plan:
1. Reset, flush to 0x1000, ack words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with no advance -> ins_o=0x0706050403020100, ins_avail_o=8, pc_o=0x1000, fetch_adr_o=0x1010, fetch_req_o=0 after the 4th word (count=16).
2. Flush to 0x1003, ack 0xDDCCBBAA -> ins_avail_o=1, ins_o[7:0]=0xDD, pc_o=0x1003, next fetch_adr_o=0x1004.
3. count=8, adv_i=1 with adv_len_i=3 in the same cycle as an accepted ack -> count=9, ins_avail_o=8, pc_o advances by 3, ins_o[7:0] = the byte previously at index 3.
4. ins_avail_o=2, adv_len_i=5 -> pc_o, count and head unchanged, adv_err_o=1 and held. A later flush clears it to 0.
5. fetch_req_o=1, flush_i=1 and fetch_ack_i=1 in the same cycle -> ack data dropped (ins_avail_o=0), fetch_req_o=0 next cycle, then 1 with fetch_adr_o = flush_pc_i & ~3.
6. flush_pc_i=0xFFFFFFFC, ack twice -> fetch_adr_o wraps to 0x00000000 then 0x00000004. Advancing 8 bytes gives pc_o=0x00000004. Asserting rst_i mid-request returns every output to its reset value the next cycle.
